// File: rtl/lsu_master_if.sv
// rtl/lsu_master_if.sv - single-beat data-memory request/acknowledge bus for lsu_master
interface lsu_master_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - load/store unit: IDLE/REQ FSM driving a single-beat data-memory bus
// Optional request timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [5:0]   op,
  input  logic [31:0]  alu_i,
  input  logic [31:0]  addr_i,
  output logic [31:0]  write_o,
  output logic         wb_valid_o,
  output logic         stall_o,
  output logic         err_o,
  lsu_master_if.master mem
);

  localparam logic [5:0] OP_LW = 6'b010001;
  localparam logic [5:0] OP_SW = 6'b010000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] write_q, write_d;
  logic        wbv_q, wbv_d;
  logic        is_mem;
  logic        timeout;
  logic [31:0] alu_result;

  assign is_mem = (op == OP_LW) || (op == OP_SW);

  always_comb begin
    alu_result = 32'h0;
    case (op[5:4])
      2'b00:   alu_result = alu_i;
      2'b10:   alu_result = addr_i;
      default: alu_result = 32'h0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // cnt_q holds the number of completed REQ cycles; the last allowed one is TIMEOUT_CYCLES-1.
  assign timeout = (state_q == REQ) && !mem.mem_ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == REQ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h0;
      wdata_q <= 32'h0;
      write_q <= 32'h0;
      wbv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      wbv_q   <= wbv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid_i && is_mem) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack_i || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are only loaded on REQ entry so they stay stable for the whole request.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    wbv_d   = 1'b0;
    stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (is_mem) begin
            stall_o = 1'b1;
            req_d   = 1'b1;
            we_d    = (op == OP_SW);
            addr_d  = addr_i[7:0];
            wdata_d = alu_i;
          end else begin
            write_d = alu_result;
            wbv_d   = 1'b1;
          end
        end
      end
      REQ: begin
        stall_o = !mem.mem_ack_i && !timeout;
        if (mem.mem_ack_i) begin
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          write_d = we_q ? 32'h0 : mem.mem_rdata_i;
        end else if (timeout) begin
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          write_d = 32'h0;
        end
      end
      default: ;
    endcase
  end

  assign write_o         = write_q;
  assign wb_valid_o      = wbv_q;
  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;

endmodule
